alu_issue_stage: RTL and testbench

//  Producer side of the ALU operand/control interface: decodes LEGv8 11-bit opcodes into
//  the 4-bit ALU control code and selects operand B (register or immediate). Buffers issued
//  ops in a small registered FIFO with valid/ready on both sides. Sits between decode and
//  the combinational ALU in the EX stage.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_op_decode.sv | 32 +++
 rtl/alu_issue_stage.sv | 68 ++++++
 tb/tb_alu_issue_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, LEGv8 opcode patterns (? = don't care) and the issue-entry struct
package alu_pkg;
  localparam int ISSUE_W = 64;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDI = 11'b1001000100?;
  localparam logic [10:0] OP_SUBI = 11'b1101000100?;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100???;
  localparam logic [10:0] OP_B    = 11'b000101?????;
  typedef struct packed {
    logic [3:0]         ctrl;
    logic [ISSUE_W-1:0] a;
    logic [ISSUE_W-1:0] b;
  } issue_entry_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational LEGv8 opcode -> {ctrl, use_imm, illegal}; ports opcode in, ctrl/use_imm/illegal out
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [3:0]  ctrl,
  output logic        use_imm,
  output logic        illegal
);
  always_comb begin
    ctrl = ALU_PASSB;
    use_imm = 1'b0;
    illegal = 1'b0;
    casez (opcode)
      OP_ADD: ctrl = ALU_ADD;
      OP_SUB: ctrl = ALU_SUB;
      OP_AND: ctrl = ALU_AND;
      OP_ORR: ctrl = ALU_ORR;
      OP_ADDI, OP_LDUR, OP_STUR: begin
        ctrl = ALU_ADD;
        use_imm = 1'b1;
      end
      OP_SUBI: begin
        ctrl = ALU_SUB;
        use_imm = 1'b1;
      end
      OP_CBZ: ctrl = ALU_PASSB;
      OP_B: use_imm = 1'b1;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode + DEPTH-entry valid/ready issue FIFO for the ALU (clk, reset async, flush, in_valid/in_ready/in_opcode/in_rn/in_rm/in_imm, out_valid/out_ready/out_ctrl/out_a/out_b, out_err, issue_cnt); ALU_ISSUE_TRAP_EN drops illegal ops and raises sticky out_err
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [10:0]       in_opcode,
  input  logic [DATA_W-1:0] in_rn,
  input  logic [DATA_W-1:0] in_rm,
  input  logic [DATA_W-1:0] in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_ctrl,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_err,
  output logic [CNT_W-1:0]  issue_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  issue_entry_t mem [DEPTH];
  issue_entry_t wd;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [3:0] dctrl;
  logic use_imm, illegal, acc, push, pop;
  alu_op_decode u_dec (.opcode(in_opcode), .ctrl(dctrl), .use_imm(use_imm), .illegal(illegal));
  assign in_ready = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign acc = in_valid && in_ready;
`ifdef ALU_ISSUE_TRAP_EN
  assign push = acc && !illegal;
  always_ff @(posedge clk or posedge reset)
    if (reset) out_err <= 1'b0;
    else if (acc && illegal) out_err <= 1'b1;
`else
  assign push = acc;
  assign out_err = 1'b0;
`endif
  assign pop = out_valid && out_ready;
  assign wd = '{ctrl: dctrl, a: ISSUE_W'(in_rn), b: ISSUE_W'(use_imm ? in_imm : in_rm)};
  // invalid head reads as zero so the idle outputs match the reset state
  assign out_ctrl = out_valid ? mem[rd_ptr].ctrl : '0;
  assign out_a = out_valid ? mem[rd_ptr].a[DATA_W-1:0] : '0;
  assign out_b = out_valid ? mem[rd_ptr].b[DATA_W-1:0] : '0;
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= wd;
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      issue_cnt <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      issue_cnt <= issue_cnt + CNT_W'(pop);
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_err;
  logic [10:0] in_opcode = '0;
  logic [63:0] in_rn = '0, in_rm = '0, in_imm = '0, out_a, out_b;
  logic [3:0] out_ctrl;
  logic [15:0] issue_cnt;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  alu_issue_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_a(out_a),
    .out_b(out_b), .out_err(out_err), .issue_cnt(issue_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [10:0] op, input logic [63:0] rn, rm, imm);
    in_valid = v;
    in_opcode = op;
    in_rn = rn;
    in_rm = rm;
    in_imm = imm;
  endtask
  logic [10:0] tab_op [8] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                              11'b10010001001, 11'b11111000000, 11'b10110100101, 11'b00010110101};
  logic [3:0] tab_ctrl [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b0111, 4'b0111};
  logic tab_imm [8] = '{0, 0, 0, 0, 1, 1, 0, 1};
  initial begin
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_a", out_a, 0);
    chk("rst_b", out_b, 0);
    chk("rst_cnt", issue_cnt, 0);
    chk("rst_err", out_err, 0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1, 11'b10001011000, 5, 3, 99);
    step();
    drive(0, 0, 0, 0, 0);
    chk("add_valid", out_valid, 1);
    chk("add_ctrl", out_ctrl, 4'b0010);
    chk("add_a", out_a, 5);
    chk("add_b", out_b, 3);
    step();
    chk("add_cnt", issue_cnt, 1);
    chk("add_drained", out_valid, 0);
    out_ready = 1'b0;
    drive(1, 11'b11010001000, 10, 7, 4);
    step();
    drive(1, 11'b11111000010, 64'h100, 9, 8);
    step();
    drive(1, 11'b10001011000, 77, 77, 77);
    chk("full_ready", in_ready, 0);
    chk("full_ctrl", out_ctrl, 4'b0110);
    step();
    drive(0, 0, 0, 0, 0);
    chk("stall_ctrl", out_ctrl, 4'b0110);
    chk("stall_a", out_a, 10);
    chk("stall_b", out_b, 4);
    out_ready = 1'b1;
    step();
    chk("ldur_ctrl", out_ctrl, 4'b0010);
    chk("ldur_a", out_a, 64'h100);
    chk("ldur_b", out_b, 8);
    chk("ldur_cnt", issue_cnt, 2);
    step();
    chk("ign_empty", out_valid, 0);
    chk("ign_cnt", issue_cnt, 3);
    out_ready = 1'b0;
    drive(1, 11'b10001011000, 1, 2, 3);
    step();
    step();
    drive(0, 0, 0, 0, 0);
    chk("pre_rst_ready", in_ready, 0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_cnt", issue_cnt, 0);
    step();
    reset = 1'b0;
    drive(1, 11'b10101010000, 100, 200, 0);
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      drive(1, 11'b10101010000, 100 + i, 200 + i, 0);
      chk("str_ctrl", out_ctrl, 4'b0001);
      chk("str_a", out_a, 100 + i - 1);
      chk("str_b", out_b, 200 + i - 1);
      step();
    end
    drive(0, 0, 0, 0, 0);
    chk("str_valid", out_valid, 1);
    chk("str_ready", in_ready, 1);
    chk("str_last", out_a, 120);
    chk("str_cnt", issue_cnt, 20);
    step();
    chk("str_drain", out_valid, 0);
    chk("str_cnt2", issue_cnt, 21);
    out_ready = 1'b0;
    drive(1, 11'b10001011000, 1, 1, 0);
    step();
    drive(1, 11'b10001011000, 2, 2, 0);
    step();
    drive(1, 11'b10001011000, 3, 3, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_cnt", issue_cnt, 0);
    drive(1, 11'b10001011000, 4, 4, 0);
    step();
    out_ready = 1'b1;
    drive(1, 11'b10001011000, 5, 5, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(0, 0, 0, 0, 0);
    chk("fl1_valid", out_valid, 0);
    chk("fl1_cnt", issue_cnt, 0);
    step();
    chk("fl1_absent", out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1, tab_op[i], i + 1, 64'h1000 + i, 64'h2000 + i);
      step();
      drive(0, 0, 0, 0, 0);
      chk("dec_ctrl", out_ctrl, tab_ctrl[i]);
      chk("dec_a", out_a, i + 1);
      chk("dec_b", out_b, tab_imm[i] ? 64'h2000 + i : 64'h1000 + i);
      step();
    end
    chk("dec_cnt", issue_cnt, 8);
    out_ready = 1'b0;
    drive(1, 11'b11111111111, 9, 11, 13);
    step();
    drive(0, 0, 0, 0, 0);
`ifdef ALU_ISSUE_TRAP_EN
    chk("ill_err", out_err, 1);
    chk("ill_valid", out_valid, 0);
`else
    chk("ill_err", out_err, 0);
    chk("ill_valid", out_valid, 1);
    chk("ill_ctrl", out_ctrl, 4'b0111);
    chk("ill_a", out_a, 9);
    chk("ill_b", out_b, 11);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
